// File: rtl/traffic_pkg.sv
// Shared constants for the traffic signal controller and its time-of-day source.
package traffic_pkg;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;

    localparam logic [HOURS_W-1:0] MAX_HOURS   = 5'd23;
    localparam logic [MIN_W-1:0]   MAX_MINUTES = 6'd59;

    localparam int DAY_START_DEF = 5;
    localparam int DAY_END_DEF   = 21;

    // Day window is half-open: [day_start, day_end).
    function automatic logic is_daytime(
        input logic [HOURS_W-1:0] hours,
        input logic [HOURS_W-1:0] day_start,
        input logic [HOURS_W-1:0] day_end
    );
        return (hours >= day_start) && (hours < day_end);
    endfunction

endpackage

// File: rtl/tod_prescaler.sv
// Modulo-N counter with enable, synchronous clear-to-zero and terminal-count flag.
module tod_prescaler #(
    parameter int N = 6000
) (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_load_zero,
    output logic o_terminal
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         w_at_last;

    assign w_at_last  = (r_count == LAST);
    // Terminal only counts when the counter is actually allowed to move.
    assign o_terminal = i_enable && w_at_last;

    // Next count: load-to-zero beats counting; frozen while disabled.
    always_comb begin
        w_count_next = r_count;
        if (i_load_zero) begin
            w_count_next = W'(0);
        end else if (i_enable) begin
            if (w_at_last) begin
                w_count_next = W'(0);
            end else begin
                w_count_next = r_count + W'(1);
            end
        end else begin
            w_count_next = r_count;
        end
    end

    // Count register, discarded on asynchronous clear.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_count <= W'(0);
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/tod_clock.sv
// Time-of-day source: minute prescaler, HH:MM counter with wrap, range-checked
// time-set command and registered daytime/tick/ack/err outputs.
module tod_clock
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_MIN = 6000,
    parameter int RESET_HOURS   = 0,
    parameter int RESET_MINUTES = 0,
    parameter int DAY_START     = DAY_START_DEF,
    parameter int DAY_END       = DAY_END_DEF
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic               set_valid,
    input  logic [HOURS_W-1:0] set_hours,
    input  logic [MIN_W-1:0]   set_minutes,
    output logic [HOURS_W-1:0] hours,
    output logic [MIN_W-1:0]   minutes,
    output logic               daytime,
    output logic               minute_tick,
    output logic               set_ack,
    output logic               set_err
);

    localparam logic [HOURS_W-1:0] RST_H   = HOURS_W'(RESET_HOURS);
    localparam logic [MIN_W-1:0]   RST_M   = MIN_W'(RESET_MINUTES);
    localparam logic [HOURS_W-1:0] DAY_S_H = HOURS_W'(DAY_START);
    localparam logic [HOURS_W-1:0] DAY_E_H = HOURS_W'(DAY_END);

    logic [HOURS_W-1:0] r_hours;
    logic [MIN_W-1:0]   r_minutes;
    logic               r_daytime;
    logic               r_minute_tick;
    logic               r_set_ack;
    logic               r_set_err;

    logic               w_terminal;
    logic               w_set_ok;
    logic               w_set_bad;
    logic               w_advance;
    logic [HOURS_W-1:0] w_next_hours;
    logic [MIN_W-1:0]   w_next_minutes;

    assign w_set_ok  = set_valid && (set_hours <= MAX_HOURS) && (set_minutes <= MAX_MINUTES);
    assign w_set_bad = set_valid && !w_set_ok;
    // An accepted set pre-empts the natural advance; a rejected one does not.
    assign w_advance = w_terminal && !w_set_ok;

    tod_prescaler #(
        .N (TICKS_PER_MIN)
    ) u_prescaler (
        .i_clock     (clock),
        .i_clear     (clear),
        .i_enable    (run),
        .i_load_zero (w_set_ok),
        .o_terminal  (w_terminal)
    );

    // Next time of day: load on accepted set, otherwise minute/hour roll-over.
    always_comb begin
        w_next_hours   = r_hours;
        w_next_minutes = r_minutes;
        if (w_set_ok) begin
            w_next_hours   = set_hours;
            w_next_minutes = set_minutes;
        end else if (w_advance) begin
            if (r_minutes == MAX_MINUTES) begin
                w_next_minutes = MIN_W'(0);
                if (r_hours == MAX_HOURS) begin
                    w_next_hours = HOURS_W'(0);
                end else begin
                    w_next_hours = r_hours + HOURS_W'(1);
                end
            end else begin
                w_next_minutes = r_minutes + MIN_W'(1);
            end
        end else begin
            w_next_hours   = r_hours;
            w_next_minutes = r_minutes;
        end
    end

    // Time, daytime (from next-state hours) and one-cycle status pulses.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_hours       <= RST_H;
            r_minutes     <= RST_M;
            r_daytime     <= is_daytime(RST_H, DAY_S_H, DAY_E_H);
            r_minute_tick <= 1'b0;
            r_set_ack     <= 1'b0;
            r_set_err     <= 1'b0;
        end else begin
            r_hours       <= w_next_hours;
            r_minutes     <= w_next_minutes;
            r_daytime     <= is_daytime(w_next_hours, DAY_S_H, DAY_E_H);
            r_minute_tick <= w_advance;
            r_set_ack     <= w_set_ok;
            r_set_err     <= w_set_bad;
        end
    end

    assign hours       = r_hours;
    assign minutes     = r_minutes;
    assign daytime     = r_daytime;
    assign minute_tick = r_minute_tick;
    assign set_ack     = r_set_ack;
    assign set_err     = r_set_err;

endmodule

// File: tb/tb_tod_clock.sv
// Directed self-checking bench for tod_clock with a 4-cycle minute.
module tb_tod_clock;

    logic       clock = 1'b0;
    logic       clear;
    logic       run;
    logic       set_valid;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       daytime;
    logic       minute_tick;
    logic       set_ack;
    logic       set_err;

    int tests_run    = 0;
    int tests_failed = 0;

    tod_clock #(
        .TICKS_PER_MIN (4),
        .RESET_HOURS   (0),
        .RESET_MINUTES (0),
        .DAY_START     (5),
        .DAY_END       (21)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .set_valid   (set_valid),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .hours       (hours),
        .minutes     (minutes),
        .daytime     (daytime),
        .minute_tick (minute_tick),
        .set_ack     (set_ack),
        .set_err     (set_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int h, input int m,
                               input int d, input int t, input int a, input int e);
        check_eq({tag, ".hours"},   int'(hours),       h);
        check_eq({tag, ".minutes"}, int'(minutes),     m);
        check_eq({tag, ".daytime"}, int'(daytime),     d);
        check_eq({tag, ".tick"},    int'(minute_tick), t);
        check_eq({tag, ".ack"},     int'(set_ack),     a);
        check_eq({tag, ".err"},     int'(set_err),     e);
    endtask

    task automatic tick_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_set(input int h, input int m);
        set_valid   = 1'b1;
        set_hours   = 5'(h);
        set_minutes = 6'(m);
        tick_cycle();
        set_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear       = 1'b0;
        run         = 1'b0;
        set_valid   = 1'b0;
        set_hours   = 5'd0;
        set_minutes = 6'd0;
        repeat (3) tick_cycle();
        check_state("reset", 0, 0, 0, 0, 0, 0);

        // Free-running minute period of 4 cycles.
        clear = 1'b1;
        run   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick_cycle();
            check_eq("period_tick", int'(minute_tick), (i % 4 == 0) ? 1 : 0);
        end
        check_eq("period_minutes", int'(minutes), 3);

        // 04:59 -> 05:00, daytime rises with the hour.
        apply_set(4, 59);
        check_state("set0459", 4, 59, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            tick_cycle();
            check_state("pre0500", 4, 59, 0, 0, 0, 0);
        end
        tick_cycle();
        check_state("roll0500", 5, 0, 1, 1, 0, 0);

        // 23:59 -> 00:00 in one edge.
        apply_set(23, 59);
        check_state("set2359", 23, 59, 0, 0, 1, 0);
        repeat (3) tick_cycle();
        tick_cycle();
        check_state("wrap0000", 0, 0, 0, 1, 0, 0);

        // Rejected sets: time unchanged, prescaler keeps going.
        tick_cycle();
        check_eq("rej_pre_tick", int'(minute_tick), 0);
        apply_set(24, 10);
        check_state("err_h24", 0, 0, 0, 0, 0, 1);
        apply_set(5, 60);
        check_state("err_m60", 0, 0, 0, 0, 0, 1);
        apply_set(24, 0);
        check_state("err_on_tc", 0, 1, 0, 1, 0, 1);

        // Accepted set on the terminal-count cycle wins, no tick.
        repeat (3) tick_cycle();
        check_eq("pre_set_tc_tick", int'(minute_tick), 0);
        apply_set(10, 30);
        check_state("set_on_tc", 10, 30, 1, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            tick_cycle();
            check_eq("post_set_notick", int'(minute_tick), 0);
        end
        tick_cycle();
        check_state("post_set_tick", 10, 31, 1, 1, 0, 0);

        // run low for 3 cycles mid-minute stretches the minute by 3.
        for (int i = 1; i <= 7; i++) begin
            run = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            tick_cycle();
            check_eq("stretch_tick", int'(minute_tick), (i == 7) ? 1 : 0);
        end
        run = 1'b1;
        check_eq("stretch_minutes", int'(minutes), 32);

        // Back-to-back sets: last one wins.
        set_valid   = 1'b1;
        set_hours   = 5'd1;
        set_minutes = 6'd2;
        tick_cycle();
        check_state("set_b2b_1", 1, 2, 0, 0, 1, 0);
        set_hours   = 5'd11;
        set_minutes = 6'd15;
        tick_cycle();
        set_valid   = 1'b0;
        check_state("set_b2b_2", 11, 15, 1, 0, 1, 0);
        tick_cycle();
        check_eq("b2b_ack_drop", int'(set_ack), 0);

        // Asynchronous clear mid-minute at 12:34.
        apply_set(12, 34);
        check_state("set1234", 12, 34, 1, 0, 1, 0);
        repeat (2) tick_cycle();
        #1 clear = 1'b0;
        #1;
        check_state("async_clear", 0, 0, 0, 0, 0, 0);
        repeat (2) tick_cycle();
        clear = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick_cycle();
            check_eq("post_clear_tick", int'(minute_tick), (i == 4) ? 1 : 0);
        end
        check_eq("post_clear_minutes", int'(minutes), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
